update_scheduler: RTL and testbench

Sequencer that owns the pixel_updater command port. After reset it runs the display-initialisation command once. It then serialises cell-redraw requests from game logic through a small FIFO, one request at a time, to pixel_updater. It also provides a full-grid clear sweep over the 16x16 cell grid. It sits between the game/board logic and pixel_updater, and is the only driver of `init_cycle`, `en_update`, `x`, `y` and `obj_code`.

---
 rtl/update_scheduler.sv | 236 +++++++++++++++++++++++
 tb/tb_update_scheduler.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/update_scheduler.sv
`timescale 1ns/1ps
// update_scheduler
//
// Owns the pixel_updater command port. After reset it issues the display
// initialisation command once. It then hands cell-redraw requests from game
// logic to pixel_updater one at a time, taking them from a small FIFO. It also
// runs a full-grid clear sweep over the 16x16 cell grid on request.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   req_valid/req_ready redraw request handshake (see below)
//   req_x, req_y        cell column/row of the request
//   req_obj             object code of the request
//   clear_req           single-cycle pulse: schedule a full-grid clear
//   cmd_done            single-cycle pulse: current pixel_updater command done
//   init_cycle          level, high while the init command is outstanding
//   en_update           level, high while a redraw command is outstanding
//   x, y, obj_code      command operands, stable while en_update is high
//   init_done           high once the init command has completed
//   busy                high in every state except IDLE
//   overflow            sticky: a request was offered while the FIFO was full
//   state_dbg           current FSM state: 0 INIT, 1 IDLE, 2 ISSUE, 3 CLEAR,
//                       4 CLR_WAIT
//
// Handshake: a request transfers on any rising edge where req_valid and
// req_ready are both high. req_ready is simply !full, so it does not depend on
// req_valid. An offer made while req_ready is low is dropped and sets
// overflow. There is no retry.

module update_scheduler #(
  parameter int         DEPTH      = 8,
  parameter logic [2:0] CLEAR_CODE = 3'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [3:0] req_x,
  input  logic [3:0] req_y,
  input  logic [2:0] req_obj,
  output logic       req_ready,
  input  logic       clear_req,
  input  logic       cmd_done,
  output logic       init_cycle,
  output logic       en_update,
  output logic [3:0] x,
  output logic [3:0] y,
  output logic [2:0] obj_code,
  output logic       init_done,
  output logic       busy,
  output logic       overflow,
  output logic [2:0] state_dbg
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_CLEAR    = 3'd3,
    ST_CLR_WAIT = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic           init_cycle_q, init_cycle_d;
  logic           en_update_q, en_update_d;
  logic [3:0]     x_q, x_d;
  logic [3:0]     y_q, y_d;
  logic [2:0]     obj_q, obj_d;
  logic           init_done_q, init_done_d;
  logic           busy_q, busy_d;
  logic           overflow_q, overflow_d;
  logic           clr_pend_q, clr_pend_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [10:0]    mem_q [DEPTH];

  logic           full;
  logic           push;
  logic           pop;
  logic           flush;
  logic [10:0]    head;

  assign full = (count_q == CW'(DEPTH));
  assign push = req_valid && !full;
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    state_d      = state_q;
    init_cycle_d = init_cycle_q;
    en_update_d  = en_update_q;
    x_d          = x_q;
    y_d          = y_q;
    obj_d        = obj_q;
    init_done_d  = init_done_q;
    overflow_d   = overflow_q | (req_valid && full);
    clr_pend_d   = clr_pend_q;
    pop          = 1'b0;
    flush        = 1'b0;

    // A clear pulse during a sweep is ignored; otherwise it just latches.
    if (clear_req && state_q != ST_CLEAR && state_q != ST_CLR_WAIT) begin
      clr_pend_d = 1'b1;
    end

    case (state_q)
      ST_INIT: begin
        init_cycle_d = 1'b1;
        if (cmd_done) begin
          init_cycle_d = 1'b0;
          init_done_d  = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (clr_pend_q) begin
          // The sweep supersedes everything queued before it started.
          clr_pend_d  = 1'b0;
          flush       = 1'b1;
          x_d         = 4'd0;
          y_d         = 4'd0;
          obj_d       = CLEAR_CODE;
          en_update_d = 1'b1;
          state_d     = ST_CLR_WAIT;
        end else if (count_q != '0) begin
          x_d         = head[10:7];
          y_d         = head[6:3];
          obj_d       = head[2:0];
          en_update_d = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // The head stays in the FIFO until pixel_updater has finished with it.
        if (cmd_done) begin
          pop         = 1'b1;
          en_update_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      ST_CLR_WAIT: begin
        if (cmd_done) begin
          en_update_d = 1'b0;
          if (x_q == 4'd15 && y_q == 4'd15) begin
            state_d = ST_IDLE;
          end else begin
            x_d = x_q + 4'd1;
            if (x_q == 4'd15) begin
              y_d = y_q + 4'd1;
            end
            state_d = ST_CLEAR;
          end
        end
      end
      ST_CLEAR: begin
        en_update_d = 1'b1;
        state_d     = ST_CLR_WAIT;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    busy_d = (state_d != ST_IDLE);

    // FIFO bookkeeping. A flush drops only entries already stored; a push
    // on the same edge lands at the new read pointer and survives.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      count_d  = count_q - CW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      count_d  = count_d + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_INIT;
      init_cycle_q <= 1'b0;
      en_update_q  <= 1'b0;
      x_q          <= 4'd0;
      y_q          <= 4'd0;
      obj_q        <= 3'd0;
      init_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      clr_pend_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      init_cycle_q <= init_cycle_d;
      en_update_q  <= en_update_d;
      x_q          <= x_d;
      y_q          <= y_d;
      obj_q        <= obj_d;
      init_done_q  <= init_done_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
      clr_pend_q   <= clr_pend_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Storage needs no reset: the count and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_x, req_y, req_obj};
    end
  end

  assign req_ready  = !full;
  assign init_cycle = init_cycle_q;
  assign en_update  = en_update_q;
  assign x          = x_q;
  assign y          = y_q;
  assign obj_code   = obj_q;
  assign init_done  = init_done_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_update_scheduler.sv
`timescale 1ns/1ps
// Testbench for update_scheduler. Expected command stream is kept as a queue
// of {x, y, obj} built from the scenario being driven; a monitor checks every
// rising en_update against it and checks operand stability while high.

module tb_update_scheduler;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [3:0] req_x;
  logic [3:0] req_y;
  logic [2:0] req_obj;
  logic       req_ready;
  logic       clear_req;
  logic       resp_done;
  logic       man_done;
  logic       cmd_done;
  logic       init_cycle;
  logic       en_update;
  logic [3:0] x;
  logic [3:0] y;
  logic [2:0] obj_code;
  logic       init_done;
  logic       busy;
  logic       overflow;
  logic [2:0] state_dbg;

  assign cmd_done = resp_done | man_done;

  always #5 clk = ~clk;

  update_scheduler #(.DEPTH(DEPTH), .CLEAR_CODE(3'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_obj    (req_obj),
    .req_ready  (req_ready),
    .clear_req  (clear_req),
    .cmd_done   (cmd_done),
    .init_cycle (init_cycle),
    .en_update  (en_update),
    .x          (x),
    .y          (y),
    .obj_code   (obj_code),
    .init_done  (init_done),
    .busy       (busy),
    .overflow   (overflow),
    .state_dbg  (state_dbg)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [10:0] exp_q[$];
  int          rise_cnt = 0;
  logic        auto_resp = 1'b0;
  int          resp_delay = 2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic        en_prev;
    logic [10:0] held;
    logic [10:0] exp;
    en_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        en_prev = 1'b0;
      end else begin
        check("init_en_exclusive", {31'd0, init_cycle & en_update}, 32'd0);
        if (en_update || init_cycle) check("busy_when_active", {31'd0, busy}, 32'd1);
        if (en_update && !en_prev) begin
          rise_cnt++;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_cmd: got x=%0d y=%0d obj=%0d, expected no command",
                     x, y, obj_code);
          end else begin
            exp = exp_q.pop_front();
            if ({x, y, obj_code} !== exp) begin
              n_fail++;
              $display("FAIL cmd_order: got x=%0d y=%0d obj=%0d expected x=%0d y=%0d obj=%0d",
                       x, y, obj_code, exp[10:7], exp[6:3], exp[2:0]);
            end
          end
          held = {x, y, obj_code};
        end else if (en_update && en_prev) begin
          check("cmd_stable", {21'd0, x, y, obj_code}, {21'd0, held});
        end
        en_prev = en_update;
      end
    end
  end

  // ---------------- automatic pixel_updater responder ----------------
  initial begin
    int cnt;
    cnt = 0;
    resp_done = 1'b0;
    forever begin
      tick();
      if (resp_done) begin
        resp_done = 1'b0;
        cnt = 0;
      end else if (auto_resp && en_update && !rst) begin
        cnt++;
        if (cnt >= resp_delay) resp_done = 1'b1;
      end else begin
        cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [3:0] px, input logic [3:0] py, input logic [2:0] po);
    req_valid = 1'b1;
    req_x = px;
    req_y = py;
    req_obj = po;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    auto_resp = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic finish_init();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    check("init_done_set", {31'd0, init_done}, 32'd1);
  endtask

  task automatic wait_en_high(input int limit);
    for (int c = 0; c < limit; c++) begin
      if (en_update) break;
      tick();
    end
    check("en_rose", {31'd0, en_update}, 32'd1);
  endtask

  task automatic wait_drain(input int limit);
    for (int c = 0; c < limit; c++) begin
      if (exp_q.size() == 0 && !en_update && !busy) break;
      tick();
    end
    check("drain_done", exp_q.size(), 32'd0);
    check("drain_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_rises(input int target, input int limit);
    for (int c = 0; c < limit; c++) begin
      if (rise_cnt >= target) break;
      tick();
    end
    check("rise_count_reached", {31'd0, rise_cnt >= target}, 32'd1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int base;
    rst = 1'b1;
    req_valid = 1'b0;
    req_x = '0;
    req_y = '0;
    req_obj = '0;
    clear_req = 1'b0;
    man_done = 1'b0;
    repeat (2) tick();

    // Reset values
    check("rst_init_cycle", {31'd0, init_cycle}, 32'd0);
    check("rst_en_update", {31'd0, en_update}, 32'd0);
    check("rst_xy_obj", {21'd0, x, y, obj_code}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_state", {29'd0, state_dbg}, 32'd0);
    rst = 1'b0;

    // Init: cmd_done 5 cycles after release
    for (int i = 0; i < 5; i++) begin
      tick();
      check("init_cycle_high", {31'd0, init_cycle}, 32'd1);
      check("init_no_en", {31'd0, en_update}, 32'd0);
    end
    finish_init();
    check("init_cycle_low", {31'd0, init_cycle}, 32'd0);
    check("init_busy_low", {31'd0, busy}, 32'd0);
    check("init_state_idle", {29'd0, state_dbg}, 32'd1);

    // Single request (3,7,5)
    exp_q.push_back({4'd3, 4'd7, 3'd5});
    push(4'd3, 4'd7, 3'd5);
    check("single_not_yet", {31'd0, en_update}, 32'd0);
    tick();
    check("single_en", {31'd0, en_update}, 32'd1);
    check("single_x", {28'd0, x}, 32'd3);
    check("single_y", {28'd0, y}, 32'd7);
    check("single_obj", {29'd0, obj_code}, 32'd5);
    repeat (3) begin
      tick();
      check("single_hold", {31'd0, en_update}, 32'd1);
    end
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    check("single_fall", {31'd0, en_update}, 32'd0);
    check("single_busy", {31'd0, busy}, 32'd0);
    tick();
    check("single_no_reissue", {31'd0, en_update}, 32'd0);
    check("single_ready", {31'd0, req_ready}, 32'd1);

    // FIFO order and overflow: 9 pushes during INIT
    do_reset();
    for (int i = 0; i < 9; i++) begin
      logic [3:0] px, py;
      logic [2:0] po;
      px = 4'(i + 2);
      py = 4'(15 - i);
      po = 3'(i + 1);
      check("fill_ready", {31'd0, req_ready}, {31'd0, (i < DEPTH)});
      if (i < DEPTH) exp_q.push_back({px, py, po});
      push(px, py, po);
    end
    check("fill_overflow", {31'd0, overflow}, 32'd1);
    check("fill_still_init", {31'd0, init_cycle}, 32'd1);
    finish_init();
    auto_resp = 1'b1;
    wait_drain(400);
    check("fill_ready_after", {31'd0, req_ready}, 32'd1);

    // Push coincident with pop while full: dropped
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back({4'(i), 4'(i + 8), 3'(i)});
      push(4'(i), 4'(i + 8), 3'(i));
    end
    check("full_ready_low", {31'd0, req_ready}, 32'd0);
    check("full_no_overflow", {31'd0, overflow}, 32'd0);
    finish_init();
    wait_en_high(20);
    man_done = 1'b1;
    push(4'd9, 4'd9, 3'd1);
    man_done = 1'b0;
    check("swap_full_overflow", {31'd0, overflow}, 32'd1);
    check("swap_full_en_low", {31'd0, en_update}, 32'd0);
    check("swap_full_ready", {31'd0, req_ready}, 32'd1);
    auto_resp = 1'b1;
    wait_drain(400);

    // Push coincident with pop at 3 entries: both take effect
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({4'(i + 1), 4'(i + 4), 3'(i + 2)});
      push(4'(i + 1), 4'(i + 4), 3'(i + 2));
    end
    finish_init();
    wait_en_high(20);
    exp_q.push_back({4'd12, 4'd13, 3'd7});
    man_done = 1'b1;
    push(4'd12, 4'd13, 3'd7);
    man_done = 1'b0;
    check("swap3_no_overflow", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("swap3_ready", {31'd0, req_ready}, 32'd1);
      exp_q.push_back({4'(i + 10), 4'(i), 3'(i)});
      push(4'(i + 10), 4'(i), 3'(i));
    end
    check("swap3_count_full", {31'd0, req_ready}, 32'd0);
    check("swap3_overflow_clear", {31'd0, overflow}, 32'd0);
    auto_resp = 1'b1;
    wait_drain(400);

    // Clear sweep: 2 queued requests flushed, mid-sweep request served after
    do_reset();
    push(4'd1, 4'd2, 3'd3);
    push(4'd4, 4'd5, 3'd6);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int yy = 0; yy < 16; yy++) begin
      for (int xx = 0; xx < 16; xx++) begin
        exp_q.push_back({4'(xx), 4'(yy), 3'd0});
      end
    end
    base = rise_cnt;
    finish_init();
    auto_resp = 1'b1;
    wait_en_high(20);
    check("clear_first_cell", {21'd0, x, y, obj_code}, 32'd0);
    wait_rises(base + 20, 300);
    exp_q.push_back({4'd5, 4'd10, 3'd6});
    clear_req = 1'b1;
    push(4'd5, 4'd10, 3'd6);
    clear_req = 1'b0;
    wait_rises(base + 256, 2500);
    check("clear_last_en", {31'd0, en_update}, 32'd1);
    check("clear_last_cell", {21'd0, x, y, obj_code}, {21'd0, 4'd15, 4'd15, 3'd0});
    wait_drain(100);
    repeat (20) tick();
    check("clear_total_cmds", rise_cnt - base, 32'd257);

    // Reset while a command is outstanding with 4 entries held
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({4'(i + 3), 4'(i), 3'(i + 1)});
      push(4'(i + 3), 4'(i), 3'(i + 1));
    end
    finish_init();
    wait_en_high(20);
    #2;
    exp_q.delete();
    rst = 1'b1;
    #1;
    check("arst_en", {31'd0, en_update}, 32'd0);
    check("arst_init_cycle", {31'd0, init_cycle}, 32'd0);
    check("arst_xy_obj", {21'd0, x, y, obj_code}, 32'd0);
    check("arst_init_done", {31'd0, init_done}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_overflow", {31'd0, overflow}, 32'd0);
    check("arst_ready", {31'd0, req_ready}, 32'd1);
    tick();
    rst = 1'b0;
    tick();
    check("arst_reinit", {31'd0, init_cycle}, 32'd1);
    finish_init();
    repeat (5) tick();
    check("arst_fifo_empty", {31'd0, en_update}, 32'd0);
    check("arst_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
